// File: rtl/axi4_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave_regs
//   AXI4-Lite responder that holds NUM_REGS 32-bit read/write registers and
//   exports them as a flat bus to local logic. The write and read channels
//   are independent two-state FSMs, so neither channel can stall the other.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   S_AXI_AW*           : write address channel (AWADDR, AWVALID, AWREADY)
//   S_AXI_W*            : write data channel (WDATA, WSTRB, WVALID, WREADY)
//   S_AXI_B*            : write response channel (BRESP, BVALID, BREADY)
//   S_AXI_AR*           : read address channel (ARADDR, ARVALID, ARREADY)
//   S_AXI_R*            : read data channel (RDATA, RRESP, RVALID, RREADY)
//   reg_out             : register bank, reg i at bits [32i+31:32i]
// ---------------------------------------------------------------------------

// One 32-bit register with byte-lane write enables.
module axi4_lite_slave_reg_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  strb,
    input  logic [31:0] wdata,
    output logic [31:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

module axi4_lite_slave_regs #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]  reg_out
);
    localparam int IDX_W = $clog2(NUM_REGS);
    // Byte address one past the last register.
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    logic [NUM_REGS-1:0][31:0] regs;
    assign reg_out = regs;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t              wr_state, wr_state_nxt;
    logic                   aw_held, w_held;
    logic [ADDR_WIDTH-1:0]  aw_addr_q;
    logic [31:0]            w_data_q;
    logic [3:0]             w_strb_q;
    logic                   aw_rdy, w_rdy, commit;
    logic                   aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [31:0]            wr_data;
    logic [3:0]             wr_strb;
    logic                   wr_in_range, wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic                   bvalid_q;
    logic [1:0]             bresp_q;

    // A half not yet held is accepted this edge when its VALID is up, because
    // READY for that half is unconditionally high in WR_IDLE.
    always_comb begin
        wr_state_nxt = wr_state;
        aw_rdy       = 1'b0;
        w_rdy        = 1'b0;
        commit       = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                aw_rdy = !aw_held;
                w_rdy  = !w_held;
                if ((aw_held || S_AXI_AWVALID) && (w_held || S_AXI_WVALID)) begin
                    commit       = 1'b1;
                    wr_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) wr_state_nxt = WR_IDLE;
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
        if (rst) begin
            aw_rdy = 1'b0;
            w_rdy  = 1'b0;
            commit = 1'b0;
        end
    end

    assign aw_hs = S_AXI_AWVALID && aw_rdy;
    assign w_hs  = S_AXI_WVALID  && w_rdy;

    // Held values win; otherwise the handshaking bus value is used directly.
    assign wr_addr     = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data     = w_held  ? w_data_q  : S_AXI_WDATA;
    assign wr_strb     = w_held  ? w_strb_q  : S_AXI_WSTRB;
    assign wr_in_range = wr_addr < ADDR_LIMIT;
    assign wr_idx      = wr_addr[2 +: IDX_W];
    assign wr_en       = commit && wr_in_range;

    always_ff @(posedge clk) begin
        if (rst) wr_state <= WR_IDLE;
        else     wr_state <= wr_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        axi4_lite_slave_reg_word u_word (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_en && (wr_idx == IDX_W'(i))),
            .strb  (wr_strb),
            .wdata (wr_data),
            .q     (regs[i])
        );
    end

    assign S_AXI_AWREADY = aw_rdy;
    assign S_AXI_WREADY  = w_rdy;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t         rd_state, rd_state_nxt;
    logic              ar_rdy, ar_hs;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;

    always_comb begin
        rd_state_nxt = rd_state;
        ar_rdy       = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                ar_rdy = 1'b1;
                if (S_AXI_ARVALID) rd_state_nxt = RD_DATA;
            end
            RD_DATA: begin
                if (S_AXI_RREADY) rd_state_nxt = RD_IDLE;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
        if (rst) ar_rdy = 1'b0;
    end

    assign ar_hs       = S_AXI_ARVALID && ar_rdy;
    assign rd_in_range = S_AXI_ARADDR < ADDR_LIMIT;
    assign rd_idx      = S_AXI_ARADDR[2 +: IDX_W];

    always_ff @(posedge clk) begin
        if (rst) rd_state <= RD_IDLE;
        else     rd_state <= rd_state_nxt;
    end

    // regs is sampled before any same-edge write lands, so a colliding read
    // returns the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_in_range ? regs[rd_idx] : 32'h0;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_ARREADY = ar_rdy;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slave_regs
//   Directed stimulus for axi4_lite_slave_regs (NUM_REGS=8). Expected B and R
//   responses are queued when a transaction is issued; a negedge monitor pops
//   and compares them whenever the DUT completes a B or R handshake.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave_regs;
    localparam int NR = 8;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  awaddr;
    logic           awvalid, awready;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic           wvalid, wready;
    logic [1:0]     bresp;
    logic           bvalid, bready;
    logic [AW-1:0]  araddr;
    logic           arvalid, arready;
    logic [31:0]    rdata;
    logic [1:0]     rresp;
    logic           rvalid, rready;
    logic [NR*32-1:0] reg_out;

    axi4_lite_slave_regs #(.NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];   // {rdata, rresp}
    logic [31:0] m[NR];        // hand-maintained register model

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = m[i];
        return f;
    endfunction

    task automatic chk_regs(input string name);
        chk(name, 256'(reg_out), 256'(model_flat()));
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) chk("b_unexpected", 256'(bvalid), 256'(0));
                else chk("bresp", 256'(bresp), 256'(exp_b_q.pop_front()));
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) chk("r_unexpected", 256'(rvalid), 256'(0));
                else chk("rdata_rresp", 256'({rdata, rresp}), 256'(exp_r_q.pop_front()));
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 256'(exp_b_q.size() + exp_r_q.size()), 256'(0));
        #1;
    endtask

    // AW and W are raised after aw_dly / w_dly cycles respectively.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp,
                             input int aw_dly, input int w_dly);
        int  cyc = 0;
        bit  aw_done = 0, w_done = 0, aw_fire, w_fire;
        exp_b_q.push_back(resp);
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done  && (cyc >= w_dly);
            @(negedge clk);
            if (w_done)  chk("wready_after_w", 256'(wready), 256'(0));
            if (aw_done) chk("awready_after_aw", 256'(awready), 256'(0));
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk); #1;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (cyc >= 50) chk("write_timeout", 256'(cyc), 256'(0));
        @(negedge clk);
        chk("bvalid_latency", 256'(bvalid), 256'(1));
        drain();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        bit fire = 0;
        exp_r_q.push_back({data, resp});
        araddr = addr;
        arvalid = 1'b1;
        while (!fire && n < 50) begin
            @(negedge clk);
            fire = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!fire) chk("read_timeout", 256'(n), 256'(0));
        @(negedge clk);
        chk("rvalid_latency", 256'(rvalid), 256'(1));
        drain();
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arvalid = 0; rready = 1;
        for (int i = 0; i < NR; i++) m[i] = '0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("awready_in_rst", 256'({awready, wready, arready}), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_regs("reg_out_reset");
        chk("valids_reset", 256'({bvalid, rvalid}), 256'(0));
        chk("readys_after_rst", 256'({awready, wready, arready}), 256'(3'b111));
        @(posedge clk); #1;

        // AW and W together
        axi_write(32'h4, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0);
        m[1] = 32'hDEADBEEF;
        chk_regs("reg1_full_write");
        axi_read(32'h4, 32'hDEADBEEF, 2'b00);

        // W three cycles before AW
        axi_write(32'h8, 32'h12345678, 4'hF, 2'b00, 3, 0);
        m[2] = 32'h12345678;
        chk_regs("reg2_w_first");
        axi_write(32'h8, 32'h0, 4'hF, 2'b00, 0, 0);
        m[2] = 32'h0;
        chk_regs("reg2_cleared");
        // AW three cycles before W
        axi_write(32'h8, 32'h12345678, 4'hF, 2'b00, 0, 3);
        m[2] = 32'h12345678;
        chk_regs("reg2_aw_first");

        // Partial write: lanes 0 and 2 only
        axi_write(32'h4, 32'h00AA00BB, 4'b0101, 2'b00, 0, 0);
        m[1] = 32'hDEAABEBB;
        chk_regs("reg1_partial");
        axi_read(32'h4, 32'hDEAABEBB, 2'b00);

        // Top in-range register, low address bits ignored
        axi_write(32'h1F, 32'hA5A5_5A5A, 4'hF, 2'b00, 0, 0);
        m[7] = 32'hA5A5_5A5A;
        chk_regs("reg7_boundary");
        axi_read(32'h1D, 32'hA5A5_5A5A, 2'b00);

        // Out of range
        axi_write(32'h20, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0);
        chk_regs("oob_write_no_change");
        axi_read(32'h20, 32'h0, 2'b10);
        axi_write(32'h8000_0004, 32'hFFFF_FFFF, 4'hF, 2'b10, 1, 0);
        chk_regs("oob_high_no_change");

        // Read and write commit to the same register on the same edge
        axi_write(32'h0, 32'h1111_1111, 4'hF, 2'b00, 0, 0);
        m[0] = 32'h1111_1111;
        exp_b_q.push_back(2'b00);
        exp_r_q.push_back({32'h1111_1111, 2'b00});
        awaddr = 32'h0; wdata = 32'h2222_2222; wstrb = 4'hF; araddr = 32'h0;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        drain();
        m[0] = 32'h2222_2222;
        chk_regs("reg0_collide");
        axi_read(32'h0, 32'h2222_2222, 2'b00);

        // Backpressure, then reset while responses are pending
        bready = 0; rready = 0;
        awaddr = 32'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h4;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        m[3] = 32'hCAFEF00D;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_b", 256'({bvalid, bresp}), 256'({1'b1, 2'b00}));
            chk("bp_r", 256'({rvalid, rdata, rresp}), 256'({1'b1, 32'hDEAABEBB, 2'b00}));
            chk("bp_readys", 256'({awready, wready, arready}), 256'(0));
        end
        chk_regs("bp_reg3");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < NR; i++) m[i] = '0;
        chk("rst_valids", 256'({bvalid, rvalid}), 256'(0));
        chk_regs("rst_regs");
        @(posedge clk); #1;
        rst = 1'b0;
        bready = 1; rready = 1;
        @(negedge clk);
        chk("readys_after_rst2", 256'({awready, wready, arready}), 256'(3'b111));
        @(posedge clk); #1;
        axi_read(32'hC, 32'h0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
